// File: rtl/audio_ctrl_pkg.sv
// Shared control definitions for the audio compression pipeline:
// sequencer states, stage codes and the frame length.
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MDCT_RUN,
    ST_QUAN_RUN,
    ST_PACK_RUN,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_MDCT = 2'd1;
  localparam logic [1:0] STG_QUAN = 2'd2;
  localparam logic [1:0] STG_PACK = 2'd3;

  localparam int FRAME_LEN = 256;

  // Maps a RUN state to the stage code reported when its watchdog expires.
  function automatic logic [1:0] stage_code(input state_e st);
    case (st)
      ST_MDCT_RUN: stage_code = STG_MDCT;
      ST_QUAN_RUN: stage_code = STG_QUAN;
      ST_PACK_RUN: stage_code = STG_PACK;
      default:     stage_code = STG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_sched_rise_det.sv
// Registered rising-edge detector: rise is high for one cycle, one cycle
// after din goes from 0 to 1.
module rise_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_p0;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      din_p0 <= 1'b0;
      rise   <= 1'b0;
    end else begin
      din_p0 <= din;
      rise   <= din & ~din_p0;
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Frame sequencer: launches MDCT, quantizer control and packer in turn for
// each frame, counts completed/dropped frames and traps stalled stages.
module frame_sched
  import audio_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             frame_rdy,
  output logic             mdct_start,
  input  logic             mdct_done,
  output logic             quan_start,
  input  logic             quan_intr,
  output logic             pack_start,
  input  logic             pack_done,
  input  logic             clr_err,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             err_timeout,
  output logic [1:0]       err_stage
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e          state;
  state_e          state_nxt;
  logic            pending;
  logic [WD_W-1:0] wdog;

  logic mdct_rise;
  logic quan_rise;
  logic pack_rise;

  logic run_rise;
  logic run_first;
  logic accept;
  logic wd_expired;
  logic in_run;
  logic entering_run;
  logic clear_pend;

  rise_det u_mdct_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (mdct_done),
    .rise   (mdct_rise)
  );

  rise_det u_quan_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (quan_intr),
    .rise   (quan_rise)
  );

  rise_det u_pack_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (pack_done),
    .rise   (pack_rise)
  );

  assign busy = (state != ST_IDLE);

  // The registered start pulse doubles as the first-cycle flag of each RUN
  // state, so completions are masked while it is high.
  always_comb begin
    state_nxt  = state;
    run_rise   = 1'b0;
    run_first  = 1'b0;
    clear_pend = 1'b0;
    in_run     = 1'b0;

    case (state)
      ST_MDCT_RUN: begin
        run_rise  = mdct_rise;
        run_first = mdct_start;
        in_run    = 1'b1;
      end
      ST_QUAN_RUN: begin
        run_rise  = quan_rise;
        run_first = quan_start;
        in_run    = 1'b1;
      end
      ST_PACK_RUN: begin
        run_rise  = pack_rise;
        run_first = pack_start;
        in_run    = 1'b1;
      end
      default: ;
    endcase

    accept     = run_rise & ~run_first;
    wd_expired = in_run && (wdog == WD_LAST);

    case (state)
      ST_IDLE: begin
        if (pending && enable) begin
          state_nxt  = ST_MDCT_RUN;
          clear_pend = 1'b1;
        end
      end
      ST_MDCT_RUN: begin
        if (accept)          state_nxt = ST_QUAN_RUN;
        else if (wd_expired) state_nxt = ST_ERR;
      end
      ST_QUAN_RUN: begin
        if (accept)          state_nxt = ST_PACK_RUN;
        else if (wd_expired) state_nxt = ST_ERR;
      end
      ST_PACK_RUN: begin
        if (accept)          state_nxt = ST_DONE;
        else if (wd_expired) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR: begin
        if (clr_err) begin
          state_nxt  = ST_IDLE;
          clear_pend = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    entering_run = (state_nxt != state) &&
                   (state_nxt inside {ST_MDCT_RUN, ST_QUAN_RUN, ST_PACK_RUN});
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      wdog        <= '0;
      mdct_start  <= 1'b0;
      quan_start  <= 1'b0;
      pack_start  <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      err_timeout <= 1'b0;
      err_stage   <= STG_NONE;
    end else begin
      state      <= state_nxt;
      mdct_start <= (state_nxt == ST_MDCT_RUN) && (state != ST_MDCT_RUN);
      quan_start <= (state_nxt == ST_QUAN_RUN) && (state != ST_QUAN_RUN);
      pack_start <= (state_nxt == ST_PACK_RUN) && (state != ST_PACK_RUN);
      frame_done <= (state_nxt == ST_DONE);

      if (state_nxt == ST_DONE)
        frame_cnt <= frame_cnt + CNT_W'(1);

      if (entering_run)
        wdog <= '0;
      else if (in_run)
        wdog <= wdog + WD_W'(1);

      // A frame_rdy coinciding with the launch refills the slot just freed.
      if (frame_rdy) begin
        pending <= 1'b1;
        if (pending && !clear_pend && (overrun_cnt != '1))
          overrun_cnt <= overrun_cnt + CNT_W'(1);
      end else if (clear_pend) begin
        pending <= 1'b0;
      end

      if ((state_nxt == ST_ERR) && (state != ST_ERR)) begin
        err_timeout <= 1'b1;
        err_stage   <= stage_code(state);
      end else if ((state == ST_ERR) && clr_err) begin
        err_timeout <= 1'b0;
        err_stage   <= STG_NONE;
      end
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: directed table and sequences plus random stimulus
// checked each cycle against a stage-level reference model.
module tb_frame_sched;
  import audio_ctrl_pkg::*;

  localparam int T  = 16;
  localparam int CW = 4;

  localparam int I_RDY = 0;
  localparam int I_MD  = 1;
  localparam int I_QI  = 2;
  localparam int I_PD  = 3;
  localparam int I_CLR = 4;

  localparam int O_MDCT = 0;
  localparam int O_QUAN = 1;
  localparam int O_PACK = 2;
  localparam int O_FDN  = 3;
  localparam int O_ERR  = 4;

  logic          clk_in = 1'b0;
  logic          rst_n, enable, frame_rdy, mdct_done, quan_intr, pack_done, clr_err;
  logic          mdct_start, quan_start, pack_start, busy, frame_done, err_timeout;
  logic [CW-1:0] frame_cnt, overrun_cnt;
  logic [1:0]    err_stage;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: stage number 0=idle 1=mdct 2=quan 3=pack 4=done 5=err
  int       m_st, m_wd, m_ovr, m_cnt, m_stg;
  bit       m_first, m_pend, m_to;
  logic [2:0] m_q, m_r;

  typedef struct {
    logic [3:0] in;   // {frame_rdy, mdct_done, quan_intr, pack_done}
    logic [4:0] exp;  // {mdct_start, quan_start, pack_start, busy, frame_done}
  } vec_t;
  vec_t tbl [22];

  always #5 clk_in = ~clk_in;

  frame_sched #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_rdy   (frame_rdy),
    .mdct_start  (mdct_start),
    .mdct_done   (mdct_done),
    .quan_start  (quan_start),
    .quan_intr   (quan_intr),
    .pack_start  (pack_start),
    .pack_done   (pack_done),
    .clr_err     (clr_err),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt),
    .err_timeout (err_timeout),
    .err_stage   (err_stage)
  );

  function automatic logic [15:0] dut_vec();
    return {mdct_start, quan_start, pack_start, busy, frame_done, err_timeout,
            err_stage, frame_cnt, overrun_cnt};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {(m_st == 1) && m_first, (m_st == 2) && m_first, (m_st == 3) && m_first,
            m_st != 0, m_st == 4, m_to, 2'(m_stg), CW'(m_cnt), CW'(m_ovr)};
  endfunction

  task automatic model_tick(input logic r_n, input logic en, input logic rdy,
                            input logic clr, input logic [2:0] din);
    int nxt;
    bit acc, tmo, clear;
    if (!r_n) begin
      m_st = 0; m_first = 0; m_wd = 0; m_pend = 0; m_ovr = 0; m_cnt = 0;
      m_to = 0; m_stg = 0; m_q = 3'b000; m_r = 3'b000;
    end else begin
      acc = 0;
      if (m_st >= 1 && m_st <= 3) acc = !m_first && m_r[m_st-1];
      tmo = (m_st >= 1 && m_st <= 3) && !acc && (m_wd == T - 1);
      nxt = m_st;
      clear = 0;
      case (m_st)
        0: if (m_pend && en) begin nxt = 1; clear = 1; end
        1, 2, 3: if (acc) nxt = m_st + 1; else if (tmo) nxt = 5;
        4: nxt = 0;
        5: if (clr) begin nxt = 0; clear = 1; end
        default: nxt = 0;
      endcase
      if (rdy) begin
        if (m_pend && !clear && m_ovr < (1 << CW) - 1) m_ovr++;
        m_pend = 1;
      end else if (clear) m_pend = 0;
      if (nxt == 5 && m_st != 5) begin m_to = 1; m_stg = m_st; end
      else if (m_st == 5 && clr) begin m_to = 0; m_stg = 0; end
      if (nxt == 4) m_cnt = (m_cnt + 1) % (1 << CW);
      m_first = (nxt >= 1 && nxt <= 3 && nxt != m_st);
      m_wd = m_first ? 0 : m_wd + 1;
      m_r = din & ~m_q;
      m_q = din;
      m_st = nxt;
    end
  endtask

  task automatic step();
    logic r_n, en, rdy, clr;
    logic [2:0] din;
    r_n = rst_n; en = enable; rdy = frame_rdy; clr = clr_err;
    din = {pack_done, quan_intr, mdct_done};
    @(posedge clk_in);
    #1;
    model_tick(r_n, en, rdy, clr, din);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h required=%h", cyc, dut_vec(), exp_vec());
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  function automatic logic out_sel(input int s);
    case (s)
      O_MDCT:  return mdct_start;
      O_QUAN:  return quan_start;
      O_PACK:  return pack_start;
      O_FDN:   return frame_done;
      O_ERR:   return err_timeout;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_out(input int s, input int budget, input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_sel(s) && n < budget);
    chk(nm, int'(out_sel(s)), 1);
  endtask

  task automatic pulse_in(input int s);
    case (s)
      I_RDY:   frame_rdy = 1'b1;
      I_MD:    mdct_done = 1'b1;
      I_QI:    quan_intr = 1'b1;
      I_PD:    pack_done = 1'b1;
      default: clr_err   = 1'b1;
    endcase
    step();
    frame_rdy = 1'b0; mdct_done = 1'b0; quan_intr = 1'b0; pack_done = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; frame_rdy = 1'b0; mdct_done = 1'b0;
    quan_intr = 1'b0; pack_done = 1'b0; clr_err = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Drives a launched frame (mdct_start just seen) through to frame_done;
  // rdy_mask bit1/bit2 inject an extra frame_rdy during QUAN_RUN/PACK_RUN.
  task automatic serve_frame(input logic [2:0] rdy_mask);
    pulse_in(I_MD);
    wait_out(O_QUAN, 20, "quan_start");
    if (rdy_mask[1]) pulse_in(I_RDY);
    pulse_in(I_QI);
    wait_out(O_PACK, 20, "pack_start");
    if (rdy_mask[2]) pulse_in(I_RDY);
    pulse_in(I_PD);
    wait_out(O_FDN, 20, "frame_done");
  endtask

  task automatic run_frame();
    pulse_in(I_RDY);
    wait_out(O_MDCT, 6, "mdct_start");
    serve_frame(3'b000);
  endtask

  initial begin
    int n, cnt;
    for (int i = 0; i < 22; i++) begin
      tbl[i].in  = 4'b0000;
      tbl[i].exp = (i >= 1 && i <= 19) ? 5'b00010 : 5'b00000;
    end
    tbl[0].in   = 4'b1000;
    tbl[1].exp  = 5'b10010;
    tbl[6].in   = 4'b0100;
    tbl[7].exp  = 5'b01010;
    tbl[12].in  = 4'b0010;
    tbl[13].in  = 4'b0010;
    tbl[13].exp = 5'b00110;
    tbl[18].in  = 4'b0001;
    tbl[19].exp = 5'b00011;

    do_reset();
    chk("reset_outputs", int'(dut_vec()), 0);

    // Nominal frame, done 5 cycles after each start, quan_intr held 2 cycles
    for (int i = 0; i < 22; i++) begin
      {frame_rdy, mdct_done, quan_intr, pack_done} = tbl[i].in;
      step();
      chk($sformatf("nominal_row%0d", i),
          int'({mdct_start, quan_start, pack_start, busy, frame_done}), int'(tbl[i].exp));
    end
    chk("nominal_frame_cnt", int'(frame_cnt), 1);

    // Overrun: extra frame_rdy in QUAN_RUN and PACK_RUN
    do_reset();
    run_frame();
    pulse_in(I_RDY);
    wait_out(O_MDCT, 6, "ovr_first_mdct");
    serve_frame(3'b110);
    chk("ovr_count", int'(overrun_cnt), 1);
    wait_out(O_MDCT, 4, "ovr_second_mdct");
    serve_frame(3'b000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(mdct_start); end
    chk("ovr_no_third_frame", cnt, 0);
    chk("ovr_frame_cnt", int'(frame_cnt), 3);

    // Watchdog on the quantizer stage
    do_reset();
    pulse_in(I_RDY);
    wait_out(O_MDCT, 6, "to_mdct");
    pulse_in(I_MD);
    wait_out(O_QUAN, 20, "to_quan");
    n = 0; cnt = 0;
    while (!err_timeout && n < 40) begin step(); n++; cnt += int'(pack_start); end
    chk("to_latency", n, 16);
    chk("to_stage", int'(err_stage), 2);
    chk("to_no_pack", cnt, 0);
    chk("to_busy", int'(busy), 1);
    pulse_in(I_RDY);
    pulse_in(I_RDY);
    chk("to_ovr_in_err", int'(overrun_cnt), 1);
    pulse_in(I_CLR);
    chk("to_clr_flags", int'({err_timeout, err_stage, busy}), 0);
    repeat (4) step();
    chk("to_clr_drops_pending", int'(busy), 0);

    // Stray completions
    do_reset();
    pulse_in(I_MD);
    repeat (3) step();
    chk("stray_idle", int'(busy), 0);
    pulse_in(I_RDY);
    wait_out(O_MDCT, 6, "stray_mdct");
    pulse_in(I_MD);
    wait_out(O_QUAN, 20, "stray_quan");
    pulse_in(I_QI);
    wait_out(O_PACK, 20, "stray_pack");
    pulse_in(I_MD);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); cnt += int'(frame_done | quan_start); end
    chk("stray_pack_ignored", cnt, 0);
    chk("stray_pack_busy", int'(busy), 1);
    pulse_in(I_PD);
    wait_out(O_FDN, 6, "stray_frame_done");

    // Enable gating
    do_reset();
    enable = 1'b0;
    pulse_in(I_RDY);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); cnt += int'(busy); end
    chk("en_low_idle", cnt, 0);
    enable = 1'b1;
    step();
    chk("en_launch_1cyc", int'(mdct_start), 1);
    serve_frame(3'b000);

    // Counter wrap at CNT_W = 4
    do_reset();
    for (int f = 0; f < 15; f++) run_frame();
    chk("wrap_15", int'(frame_cnt), 15);
    run_frame();
    chk("wrap_16", int'(frame_cnt), 0);

    // Reset during PACK_RUN
    do_reset();
    pulse_in(I_RDY);
    wait_out(O_MDCT, 6, "rst_mdct");
    pulse_in(I_MD);
    wait_out(O_QUAN, 20, "rst_quan");
    pulse_in(I_QI);
    wait_out(O_PACK, 20, "rst_pack");
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs", int'(dut_vec()), 0);
    rst_n = 1'b1;
    pulse_in(I_PD);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(); cnt += int'(frame_done | busy); end
    chk("rst_late_pack_ignored", cnt, 0);

    // Random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int dn;
      dn = (i < 2000) ? 3 : 40;
      frame_rdy = ($urandom_range(0, 7) == 0);
      mdct_done = ($urandom_range(0, dn - 1) == 0);
      quan_intr = ($urandom_range(0, dn - 1) == 0);
      pack_done = ($urandom_range(0, dn - 1) == 0);
      clr_err   = ($urandom_range(0, 11) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
